// File: rtl/rom_bus_master_pkg.sv
// rtl/rom_bus_master_pkg.sv - subcycle phases, bus ops and strobe polarity shared by both bus ends
package rom_bus_master_pkg;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_SRC  = 2'd1,
    OP_WRR  = 2'd2,
    OP_RDR  = 2'd3
  } bus_op_e;

  localparam logic CMD_ACTIVE = 1'b0;

endpackage

// File: rtl/rom_bus_master_timer.sv
// rtl/rom_bus_master_timer.sv - free-running 8-subcycle phase counter with sync decode
module bus_cycle_timer
  import rom_bus_master_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] cycle_o,
  output logic       sync_o
);

  logic [2:0] cycle_q;
  logic [2:0] cycle_d;

  always_comb begin
    cycle_d = cycle_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= SC_A1;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_o = cycle_q;
  // Held low while reset is asserted so the far end never sees a stray cycle start.
  assign sync_o  = (cycle_q == SC_X3) && !reset;

endmodule

// File: rtl/rom_bus_master.sv
// rtl/rom_bus_master.sv - CPU-side initiator for the 4-bit multiplexed ROM/IO bus
module rom_bus_master
  import rom_bus_master_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [3:0]  data,
  output logic        sync,
  output logic        cmd,
  input  logic [11:0] pc_i,
  input  logic [1:0]  op_i,
  input  logic [7:0]  op_data_i,
  output logic [2:0]  cycle_o,
  output logic [7:0]  instr_o,
  output logic        instr_valid_o,
  output logic [3:0]  rd_data_o,
  output logic        rd_valid_o
);

  logic [2:0] cycle;

  bus_cycle_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .cycle_o (cycle),
    .sync_o  (sync)
  );

  logic [11:0] pc_q,          pc_d;
  bus_op_e     op_q,          op_d;
  logic [7:0]  op_data_q,     op_data_d;
  logic [3:0]  opr_q,         opr_d;
  logic [7:0]  instr_q,       instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [3:0]  rd_data_q,     rd_data_d;
  logic        rd_valid_q,    rd_valid_d;

  always_comb begin
    pc_d          = pc_q;
    op_d          = op_q;
    op_data_d     = op_data_q;
    opr_d         = opr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    case (cycle)
      SC_M1: opr_d = data;
      SC_M2: begin
        // OPA is taken straight off the bus so the full byte is ready in X1.
        instr_d       = {opr_q, data};
        instr_valid_d = 1'b1;
      end
      SC_X2: begin
        if (op_q == OP_RDR) begin
          rd_data_d  = data;
          rd_valid_d = 1'b1;
        end
      end
      SC_X3: begin
        pc_d      = pc_i;
        op_d      = bus_op_e'(op_i);
        op_data_d = op_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      op_q          <= OP_NONE;
      op_data_q     <= 8'h00;
      opr_q         <= 4'h0;
      instr_q       <= 8'h00;
      instr_valid_q <= 1'b0;
      rd_data_q     <= 4'h0;
      rd_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      op_q          <= op_d;
      op_data_q     <= op_data_d;
      opr_q         <= opr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  logic       drive_en;
  logic [3:0] drive_val;
  logic       cmd_n;

  // Bus controls depend only on registered phase and op, never on the core inputs.
  always_comb begin
    drive_en  = 1'b0;
    drive_val = 4'h0;
    cmd_n     = ~CMD_ACTIVE;
    case (cycle)
      SC_A1: begin drive_en = 1'b1; drive_val = pc_q[3:0];  end
      SC_A2: begin drive_en = 1'b1; drive_val = pc_q[7:4];  end
      SC_A3: begin drive_en = 1'b1; drive_val = pc_q[11:8]; end
      SC_M2: begin
        if (op_q == OP_WRR || op_q == OP_RDR) cmd_n = CMD_ACTIVE;
      end
      SC_X2: begin
        if (op_q == OP_SRC) begin
          drive_en  = 1'b1;
          drive_val = op_data_q[7:4];
          cmd_n     = CMD_ACTIVE;
        end else if (op_q == OP_WRR) begin
          drive_en  = 1'b1;
          drive_val = op_data_q[3:0];
        end
      end
      SC_X3: begin
        if (op_q == OP_SRC) begin
          drive_en  = 1'b1;
          drive_val = op_data_q[3:0];
        end
      end
      default: ;
    endcase
    if (reset) begin
      drive_en = 1'b0;
      cmd_n    = ~CMD_ACTIVE;
    end
  end

  assign data          = drive_en ? drive_val : 4'bz;
  assign cmd           = cmd_n;
  assign cycle_o       = cycle;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;

endmodule

// File: tb/tb_rom_bus_master.sv
// tb/tb_rom_bus_master.sv - scoreboard bench with ROM and I/O responder models on the shared bus
module tb_rom_bus_master;
  import rom_bus_master_pkg::*;

  localparam logic [11:0] RST_PC = 12'h000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc_i = 12'h000;
  logic [1:0]  op_i = 2'd0;
  logic [7:0]  op_data_i = 8'h00;
  wire  [3:0]  data;
  logic        sync, cmd;
  logic [2:0]  cycle_o;
  logic [7:0]  instr_o;
  logic        instr_valid_o;
  logic [3:0]  rd_data_o;
  logic        rd_valid_o;

  logic        tb_en = 1'b0;
  logic [3:0]  tb_val = 4'h0;

  // An undriven bus floats to all ones, so a released bus reads as 4'hF.
  assign data = tb_en ? tb_val : 4'bz;
  pullup (data[0]);
  pullup (data[1]);
  pullup (data[2]);
  pullup (data[3]);

  always #5 clock = ~clock;

  rom_bus_master #(.RESET_PC(RST_PC)) dut (
    .clock         (clock),
    .reset         (reset),
    .data          (data),
    .sync          (sync),
    .cmd           (cmd),
    .pc_i          (pc_i),
    .op_i          (op_i),
    .op_data_i     (op_data_i),
    .cycle_o       (cycle_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o)
  );

  typedef struct {
    logic [2:0] cyc;
    logic [3:0] dat;
    logic       cmd;
    logic       sync;
    logic       ivalid;
    logic [7:0] instr;
    logic       rvalid;
    logic [3:0] rd;
    bus_op_e    op;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rom_mem [logic [11:0]];
  int         n_vec = 0;
  int         n_err = 0;

  logic [11:0] tb_addr;
  logic [7:0]  tb_rom;
  logic [3:0]  resp_chip, resp_reg, resp_io, resp_io_instr;
  logic        resp_sel, src_pend;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_cycle(input logic [11:0] pc, input bus_op_e op,
                            input logic [7:0] od, input logic [3:0] rdn);
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      e.cyc    = s[2:0];
      e.dat    = 4'hF;
      e.cmd    = 1'b1;
      e.sync   = (s == 7);
      e.ivalid = (s == 5);
      e.instr  = rom_mem.exists(pc) ? rom_mem[pc] : 8'h00;
      e.rvalid = (s == 7) && (op == OP_RDR);
      e.rd     = rdn;
      e.op     = op;
      case (s)
        0: e.dat = pc[3:0];
        1: e.dat = pc[7:4];
        2: e.dat = pc[11:8];
        4: if (op == OP_WRR || op == OP_RDR) e.cmd = 1'b0;
        6: begin
          if (op == OP_SRC) begin e.dat = od[7:4]; e.cmd = 1'b0; end
          else if (op == OP_WRR) e.dat = od[3:0];
        end
        7: if (op == OP_SRC) e.dat = od[3:0];
        default: ;
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clock);
    tb_en = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
      $fatal(1);
    end
    e = exp_q.pop_front();
    check($sformatf("cycle@sc%0d", e.cyc),  12'(cycle_o),       12'(e.cyc));
    check($sformatf("data@sc%0d", e.cyc),   12'(data),          12'(e.dat));
    check($sformatf("cmd@sc%0d", e.cyc),    12'(cmd),           12'(e.cmd));
    check($sformatf("sync@sc%0d", e.cyc),   12'(sync),          12'(e.sync));
    check($sformatf("ivalid@sc%0d", e.cyc), 12'(instr_valid_o), 12'(e.ivalid));
    check($sformatf("rvalid@sc%0d", e.cyc), 12'(rd_valid_o),    12'(e.rvalid));
    if (e.cyc == 3'd5) check("instr", 12'(instr_o), 12'(e.instr));
    if (e.rvalid) check("rd_data", 12'(rd_data_o), 12'(e.rd));
    case (e.cyc)
      3'd0: tb_addr[3:0]  = data;
      3'd1: tb_addr[7:4]  = data;
      3'd2: tb_addr[11:8] = data;
      3'd3: begin
        tb_rom = rom_mem.exists(tb_addr) ? rom_mem[tb_addr] : 8'h00;
        tb_en  = 1'b1;
        tb_val = tb_rom[7:4];
      end
      3'd4: begin
        if (cmd == 1'b0) resp_io_instr = tb_rom[3:0];
        tb_en  = 1'b1;
        tb_val = tb_rom[3:0];
      end
      3'd6: begin
        if (cmd == 1'b0) begin
          resp_chip = data;
          src_pend  = 1'b1;
        end else if (resp_io_instr == 4'h2 && resp_sel) begin
          resp_io = data;
        end
        if (e.op == OP_RDR) begin
          tb_en  = 1'b1;
          tb_val = e.rd;
        end
      end
      3'd7: begin
        if (src_pend) begin
          resp_reg = data;
          resp_sel = (resp_chip == 4'h0);
          src_pend = 1'b0;
        end
        resp_io_instr = 4'hF;
      end
      default: ;
    endcase
  endtask

  task automatic run_cycle(input logic [11:0] pc, input bus_op_e op, input logic [7:0] od,
                           input logic [7:0] rom, input logic [3:0] rdn);
    repeat (8) step();
    pc_i        = pc;
    op_i        = op;
    op_data_i   = od;
    rom_mem[pc] = rom;
    push_cycle(pc, op, od, rdn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    tb_addr = 12'h000; tb_rom = 8'h00;
    resp_chip = 4'h0; resp_reg = 4'h0; resp_io = 4'h0; resp_io_instr = 4'hF;
    resp_sel = 1'b0; src_pend = 1'b0;
    rom_mem[RST_PC] = 8'h12;
    pc_i = 12'h5A3;
    op_i = OP_NONE;

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_cycle",  12'(cycle_o),       12'd0);
    check("rst_data",   12'(data),          12'hF);
    check("rst_cmd",    12'(cmd),           12'd1);
    check("rst_sync",   12'(sync),          12'd0);
    check("rst_instr",  12'(instr_o),       12'h00);
    check("rst_ivalid", 12'(instr_valid_o), 12'd0);
    check("rst_rd",     12'(rd_data_o),     12'h0);
    check("rst_rvalid", 12'(rd_valid_o),    12'd0);

    @(posedge clock);
    #1;
    reset = 1'b0;
    push_cycle(RST_PC, OP_NONE, 8'h00, 4'h0);

    run_cycle(12'h5A3, OP_NONE, 8'h00, 8'hD7, 4'h0);
    run_cycle(12'h5A4, OP_SRC,  8'h0C, 8'h21, 4'h0);
    run_cycle(12'h5A5, OP_WRR,  8'h09, 8'hE2, 4'h0);
    check("resp_sel", 12'(resp_sel), 12'd1);
    check("resp_reg", 12'(resp_reg), 12'hC);
    run_cycle(12'h5A6, OP_RDR,  8'h00, 8'hE9, 4'h6);
    check("resp_io",  12'(resp_io),  12'h9);
    run_cycle(12'h5A7, OP_RDR,  8'h00, 8'hE9, 4'h3);
    run_cycle(12'h5A8, OP_SRC,  8'h0C, 8'h21, 4'h0);

    repeat (7) step();
    reset = 1'b1;
    pc_i  = 12'h0AB;
    op_i  = OP_NONE;
    op_data_i = 8'h00;
    #1;
    check("midrst_cmd",  12'(cmd),  12'd1);
    check("midrst_data", 12'(data), 12'hF);
    check("midrst_sync", 12'(sync), 12'd0);
    repeat (2) begin
      @(negedge clock);
      #1;
      check("inrst_cycle",  12'(cycle_o),       12'd0);
      check("inrst_cmd",    12'(cmd),           12'd1);
      check("inrst_data",   12'(data),          12'hF);
      check("inrst_ivalid", 12'(instr_valid_o), 12'd0);
      check("inrst_rvalid", 12'(rd_valid_o),    12'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    src_pend = 1'b0;
    resp_io_instr = 4'hF;
    push_cycle(RST_PC, OP_NONE, 8'h00, 4'h0);

    repeat (3) step();
    op_i      = OP_SRC;
    op_data_i = 8'h55;
    repeat (5) step();
    pc_i      = 12'h0AB;
    op_i      = OP_NONE;
    op_data_i = 8'h00;
    rom_mem[12'h0AB] = 8'h3C;
    push_cycle(12'h0AB, OP_NONE, 8'h00, 4'h0);
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_bus_master.md
Name: rom_bus_master

Overview:
- CPU-side initiator for the 4-bit multiplexed ROM/IO bus; the other end of the ROM responder.
- Free-running 8-subcycle instruction cycle: drives the 12-bit fetch address, samples the 8-bit instruction, drives sync and cmd.
- Executes the X-phase bus operations the core requests:
  - SRC chip/register select
  - output-port write (WRR)
  - port read (RDR)
- Sits between the CPU core/sequencer and the shared data bus.

Parameters:
RESET_PC, 12'h000, fetch address presented in the first cycle after reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
data  inout  4  multiplexed bus; driven only in master-drive subcycles, else 4'bz
sync  out  1  high during subcycle 7 (marks next cycle start)
cmd  out  1  active-low command strobe
pc_i  in  12  next fetch address, sampled at end of subcycle 7
op_i  in  2  X-phase op for next cycle: 0 NONE, 1 SRC, 2 WRR, 3 RDR; sampled with pc_i
op_data_i  in  8  SRC: {chip_id, reg}; WRR: [3:0] = port data; sampled with pc_i
cycle_o  out  3  current subcycle
instr_o  out  8  {OPR, OPA} of last fetch
instr_valid_o  out  1  one-clock pulse in subcycle 5
rd_data_o  out  4  nibble captured in subcycle 6 of an RDR cycle
rd_valid_o  out  1  one-clock pulse in subcycle 7 of an RDR cycle

Behaviour:
- Reset state:
  - cycle = 0
  - pc register = RESET_PC, op = NONE
  - instr_o = 0, rd_data_o = 0
  - instr_valid_o = 0, rd_valid_o = 0
  - sync = 0, cmd = 1
  - data = z while reset is high
- cycle increments by 1 per clock and wraps 7 -> 0.
- Subcycle map (0 A1, 1 A2, 2 A3, 3 M1, 4 M2, 5 X1, 6 X2, 7 X3):
  - 0: drive pc[3:0]
  - 1: drive pc[7:4]
  - 2: drive pc[11:8]
  - 3: tristate; register data into opr
  - 4: tristate; register data into opa
  - 5: instr_o = {opr, opa}; instr_valid_o = 1
  - 6:
    - SRC: drive op_data[7:4], cmd = 0
    - WRR: drive op_data[3:0]
    - RDR: tristate; register data into rd_data_o
    - NONE: tristate
  - 7:
    - SRC: drive op_data[3:0]
    - RDR: rd_valid_o = 1
    - sync = 1 in every cycle
    - pc and op are reloaded from pc_i/op_i/op_data_i at the end of this subcycle
- cmd = 0 in subcycle 4 when op is WRR or RDR, so the responder latches its I/O instruction. Otherwise cmd = 1, except subcycle 6 of SRC (see above).
- Ops are latched once per cycle. Changes on op_i outside the end of subcycle 7 have no effect on the cycle in progress.
- data output enable, sync and cmd are decoded from the registered cycle/op: glitch-free, no combinational path from core inputs.
- The master never drives data in subcycles 3 and 4, when the ROM drives the bus.
- Reset mid-cycle:
  - the next clock returns to subcycle 0 with RESET_PC
  - any pending op is discarded
  - no valid pulse is emitted
- Back-to-back SRC/WRR/RDR in consecutive cycles is legal. Each cycle is independent.
- pc wrap (12'hFFF) is the core's responsibility; the master presents whatever it latched.

Decomposition:
- Shared package:
  - subcycle constants (SC_A1..SC_X3)
  - op enum (OP_NONE, OP_SRC, OP_WRR, OP_RDR)
  - CMD_ACTIVE = 1'b0
- One sub-module: bus_cycle_timer (3-bit counter, reset, sync decode). The responder should also reuse it so both ends share the phase definition.

Test Plan:
- Reset released with RESET_PC = 0, pc_i = 12'h5A3, op NONE:
  - cycle 0 data = 0
  - sync pulses at cycle 7
  - next cycle drives 3, A, 5 in subcycles 0..2
  - data = z in all other subcycles
- ROM model at address 12'h5A3 holding 8'hD7 -> instr_valid_o pulses in subcycle 5 with instr_o = 8'hD7; no bus contention in subcycles 3-4.
- op SRC, op_data 8'h0C, paired with responder:
  - subcycle 6: cmd = 0, data = 0
  - subcycle 7: data = C, cmd = 1
  - responder reports selected
- Following cycle op WRR, op_data 8'h09, ROM OPA = 2:
  - cmd = 0 in subcycle 4
  - data = 9 in subcycle 6
  - responder io = 4'h9 after that cycle
- op RDR, external model drives 4'h6 in subcycle 6 -> rd_valid_o pulses in subcycle 7 with rd_data_o = 4'h6; master tristate in subcycle 6.
- reset asserted in subcycle 6 of an SRC cycle:
  - cmd returns to 1 and data = z immediately while reset is high
  - after release: cycle restarts at 0 with RESET_PC, no valid pulses
